serial_parity_checker: RTL and testbench



---
 rtl/serial_parity_checker_pkg.sv | 19 +
 rtl/serial_parity_checker_parity_acc_cell.sv | 24 ++
 rtl/serial_parity_checker.sv | 109 ++++++++++
 tb/tb_serial_parity_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial frame parity checker: FSM encodings,
// parity-sense constants and the two-input XOR primitive the accumulator folds through.
package serial_parity_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic xor2(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/serial_parity_checker_parity_acc_cell.sv
// One-bit parity accumulator: synchronous clear wins over enable; when enabled,
// the stored bit is folded with d through the XOR primitive.
module parity_acc_cell
  import serial_parity_checker_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= xor2(q, d);
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial frame parity checker: folds DATA_BITS data bits into a running XOR,
// then compares against the trailing parity bit and reports via done/parity_err.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start; bit_valid ignored
// ST_DATA   | accepting data bits into the accumulator and counter
// ST_PARITY | waiting for the trailing parity bit
// ST_DONE   | one-cycle done pulse; start here begins the next frame
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int  DATA_BITS = 8,
  parameter int  ODD       = 0,
  localparam int CW        = $clog2(DATA_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          busy,
  output logic          done,
  output logic          parity_err,
  output logic          parity_acc,
  output logic [CW-1:0] bit_count
);

  localparam logic          ODD_BIT  = (ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] bit_count_q;
  logic          parity_err_q;
  logic          data_take;
  logic          parity_take;

  // start has priority over any bit presented on the same edge
  assign data_take   = (state_q == ST_DATA)   && bit_valid && !start;
  assign parity_take = (state_q == ST_PARITY) && bit_valid && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_DATA;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_DATA:   if (data_take && (bit_count_q == CNT_LAST)) state_d = ST_PARITY;
        ST_PARITY: if (parity_take) state_d = ST_DONE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_DATA, ST_PARITY: busy = 1'b1;
      ST_DONE:            done = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count_q <= '0;
    end else if (start) begin
      bit_count_q <= '0;
    end else if (data_take && (bit_count_q != CNT_FULL)) begin
      bit_count_q <= bit_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (start) begin
      parity_err_q <= 1'b0;
    end else if (parity_take) begin
      parity_err_q <= xor2(parity_acc, bit_in) != ODD_BIT;
    end
  end

  parity_acc_cell u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (data_take),
    .d     (bit_in),
    .q     (parity_acc)
  );

  assign bit_count  = bit_count_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: even and odd parity instances share one stimulus stream and are
// checked against hand-computed frame results.
module tb_serial_parity_checker;

  localparam int DB = 8;
  localparam int CW = $clog2(DB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;

  logic          busy_e, done_e, err_e, acc_e;
  logic [CW-1:0] cnt_e;
  logic          busy_o, done_o, err_o, acc_o;
  logic [CW-1:0] cnt_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_BITS(DB), .ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_e), .done(done_e), .parity_err(err_e), .parity_acc(acc_e), .bit_count(cnt_e)
  );

  serial_parity_checker #(.DATA_BITS(DB), .ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_o), .done(done_o), .parity_err(err_o), .parity_acc(acc_o), .bit_count(cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {busy_e, busy_o}, 0);
    chk({tag, "_done"}, {done_e, done_o}, 0);
    chk({tag, "_err"},  {err_e, err_o}, 0);
    chk({tag, "_acc"},  {acc_e, acc_o}, 0);
    chk({tag, "_cnt"},  {cnt_e, cnt_o}, 0);
  endtask

  // Sends one frame (optionally starting it) and checks every step.
  task automatic send_frame(input logic [7:0] data, input logic par, input int gap_max,
                            input bit do_start);
    logic run;
    logic exp_e;
    logic exp_o;
    int   cyc;
    cyc = 0;
    run = 1'b0;
    if (do_start) begin
      start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1;
      chk("start_busy", busy_e, 1);
      chk("start_cnt", cnt_e, 0);
      chk("start_acc", acc_e, 0);
      chk("start_err", {err_e, err_o}, 0);
    end
    for (int i = 0; i < DB; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        bit_in = 1'($urandom_range(1, 0));
        tick;
        cyc++;
        chk("gap_cnt", cnt_e, i);
        chk("gap_acc", acc_e, run);
      end
      bit_valid = 1'b1;
      bit_in = data[i];
      tick;
      cyc++;
      bit_valid = 1'b0;
      run = run ^ data[i];
      chk("data_cnt", {cnt_e, cnt_o}, {CW'(i + 1), CW'(i + 1)});
      chk("data_acc", {acc_e, acc_o}, {run, run});
      chk("data_done", {done_e, done_o}, 0);
      chk("data_busy", busy_e, 1);
    end
    bit_valid = 1'b1;
    bit_in = par;
    tick;
    cyc++;
    bit_valid = 1'b0;
    exp_e = run ^ par;
    exp_o = ~(run ^ par);
    chk("done_pulse", {done_e, done_o}, 2'b11);
    chk("err_even", err_e, exp_e);
    chk("err_odd", err_o, exp_o);
    chk("final_acc", acc_e, run);
    chk("final_cnt", cnt_e, DB);
    chk("done_busy", busy_e, 0);
    if (gap_max == 0 && do_start) chk("latency", cyc, DB + 2);
    tick;
    chk("done_drop", {done_e, done_o}, 0);
    chk("err_held", {err_e, err_o}, {exp_e, exp_o});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;

    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick;
    tick;
    bit_valid = 1'b0;
    chk_all_zero("idle_ignore");

    // bits 1,0,1,1,0,0,1,0 (LSB first), four ones
    send_frame(8'b0100_1101, 1'b0, 0, 1'b1);
    send_frame(8'b0100_1101, 1'b1, 0, 1'b1);
    tick;
    tick;
    chk("err_hold_idle", err_e, 1);
    send_frame(8'h01, 1'b0, 0, 1'b1);
    send_frame(8'h01, 1'b1, 0, 1'b1);

    send_frame(8'b0100_1101, 1'b1, 5, 1'b1);
    send_frame(8'hA7, 1'b0, 5, 1'b1);

    // abort after 5 data bits; the start edge also carries a bit_valid
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick;
    end
    chk("pre_abort_cnt", cnt_e, 5);
    start = 1'b1;
    tick;
    start = 1'b0;
    bit_valid = 1'b0;
    chk("abort_cnt", cnt_e, 0);
    chk("abort_acc", acc_e, 0);
    chk("abort_err", err_e, 0);
    chk("abort_busy", busy_e, 1);
    chk("abort_done", done_e, 0);
    send_frame(8'hC3, 1'b1, 1, 1'b0);

    // async reset while waiting for the parity bit
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < DB; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'(i % 3 == 0);
      tick;
    end
    bit_valid = 1'b0;
    chk("pre_rst_busy", busy_e, 1);
    chk("pre_rst_acc", acc_e, 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    #1 rst_n = 1'b1;
    tick;
    chk_all_zero("post_rst");
    send_frame(8'h5A, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
